hs_fifo_pipeline: RTL



---
 rtl/hs_fifo_pipeline.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hs_fifo_pipeline.sv
// Clocked FIFO between two four-phase req/ack channels, with optional input
// synchronisers and registered occupancy/full/empty status.
module hs_fifo_pipeline #(
  parameter int WIDTH       = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       req_in,
  output logic                       ack_out,
  output logic [WIDTH-1:0]           data_out,
  output logic                       req_out,
  input  logic                       ack_in,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_state_t;

  logic req_s, ack_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req_in;
      assign ack_s = ack_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] req_sync_reg, ack_sync_reg;
      // Shift chain: bit 0 takes the raw input, the top bit is the synchronised copy.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          req_sync_reg <= '0;
          ack_sync_reg <= '0;
        end else begin
          req_sync_reg <= SYNC_STAGES'({req_sync_reg, req_in});
          ack_sync_reg <= SYNC_STAGES'({ack_sync_reg, ack_in});
        end
      end
      assign req_s = req_sync_reg[SYNC_STAGES-1];
      assign ack_s = ack_sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             ack_out_reg, ack_out_next;
  logic             req_out_reg, req_out_next;
  logic [WIDTH-1:0] data_out_reg, data_out_next;
  in_state_t        in_state_reg, in_state_next;
  out_state_t       out_state_reg, out_state_next;
  logic             wr_en, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_state_next = in_state_reg;
    ack_out_next  = ack_out_reg;
    wr_en         = 1'b0;
    case (in_state_reg)
      IN_IDLE: if (req_s && !full_reg) begin
        wr_en         = 1'b1;
        ack_out_next  = 1'b1;
        in_state_next = IN_ACK;
      end
      IN_ACK: if (!req_s) begin
        ack_out_next  = 1'b0;
        in_state_next = IN_IDLE;
      end
      default: in_state_next = IN_IDLE;
    endcase
  end

  // A lingering ack from the previous word blocks a new request until it drops.
  always_comb begin
    out_state_next = out_state_reg;
    req_out_next   = req_out_reg;
    data_out_next  = data_out_reg;
    pop            = 1'b0;
    case (out_state_reg)
      OUT_IDLE: if (!empty_reg && !ack_s) begin
        data_out_next  = mem[rd_ptr_reg];
        req_out_next   = 1'b1;
        out_state_next = OUT_REQ;
      end
      OUT_REQ: if (ack_s) begin
        pop            = 1'b1;
        req_out_next   = 1'b0;
        out_state_next = OUT_RTZ;
      end
      OUT_RTZ: if (!ack_s) out_state_next = OUT_IDLE;
      default: out_state_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_reg  <= IN_IDLE;
      out_state_reg <= OUT_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      ack_out_reg   <= 1'b0;
      req_out_reg   <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      in_state_reg  <= in_state_next;
      out_state_reg <= out_state_next;
      if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)   rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg     <= count_next;
      full_reg      <= (count_next == CNT_W'(DEPTH));
      empty_reg     <= (count_next == '0);
      ack_out_reg   <= ack_out_next;
      req_out_reg   <= req_out_next;
      data_out_reg  <= data_out_next;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= data_in;
  end

  assign ack_out  = ack_out_reg;
  assign req_out  = req_out_reg;
  assign data_out = data_out_reg;
  assign count    = count_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
endmodule
